fcp_update_gen: RTL and testbench



---
 rtl/fcp_pkg.sv | 38 +++
 rtl/fcp_vc_state.sv | 66 ++++++
 rtl/fcp_update_gen.sv | 78 +++++++
 tb/tb_fcp_update_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fcp_pkg.sv
// fcp_pkg: FCP update word layout shared by the credit generator and the sink adapter.
package fcp_pkg;
   localparam int FCP_FCCL_LSB = 0;
   localparam int FCP_QLEN_LSB = 32;
   localparam int FCP_FCCR_LSB = 64;
   localparam int FCP_VC_LSB   = 96;
   localparam int FCP_STAT_W   = 32;
   localparam int FCP_VC_W     = 15;
   localparam int FCP_WORD_W   = 128;

   typedef enum logic {SCAN, SEND} fcp_state_e;

   typedef struct packed {
      logic [FCP_VC_W-1:0]   vc;
      logic [FCP_STAT_W-1:0] fccr;
      logic [FCP_STAT_W-1:0] qlen;
      logic [FCP_STAT_W-1:0] fccl;
   } fcp_upd_t;

   function automatic logic [FCP_WORD_W-1:0] fcp_pack(input fcp_upd_t u);
      logic [FCP_WORD_W-1:0] w;
      w = '0;
      w[FCP_FCCL_LSB +: FCP_STAT_W] = u.fccl;
      w[FCP_QLEN_LSB +: FCP_STAT_W] = u.qlen;
      w[FCP_FCCR_LSB +: FCP_STAT_W] = u.fccr;
      w[FCP_VC_LSB +: FCP_VC_W]     = u.vc;
      return w;
   endfunction

   function automatic fcp_upd_t fcp_unpack(input logic [FCP_WORD_W-1:0] w);
      fcp_upd_t u;
      u.fccl = w[FCP_FCCL_LSB +: FCP_STAT_W];
      u.qlen = w[FCP_QLEN_LSB +: FCP_STAT_W];
      u.fccr = w[FCP_FCCR_LSB +: FCP_STAT_W];
      u.vc   = w[FCP_VC_LSB +: FCP_VC_W];
      return u;
   endfunction
endpackage

// File: rtl/fcp_vc_state.sv
// fcp_vc_state: per-VC received/occupancy counters with dirty and refresh flags,
// plus one combinational read port for the scanner.
module fcp_vc_state
   import fcp_pkg::*;
#(
   parameter int NUM_VC            = 16,
   parameter int QUEUE_INDEX_WIDTH = 15,
   parameter int STAT_WIDTH        = 32,
   parameter int BUF_LIMIT         = 1024,
   parameter int PW                = $clog2(NUM_VC)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enq_valid,
   input  logic [QUEUE_INDEX_WIDTH-1:0] enq_vc,
   input  logic                         deq_valid,
   input  logic [QUEUE_INDEX_WIDTH-1:0] deq_vc,
   input  logic                         refresh_all,
   input  logic                         clr,
   input  logic [PW-1:0]                idx,
   output logic [STAT_WIDTH-1:0]        rd_fccr,
   output logic [STAT_WIDTH-1:0]        rd_qlen,
   output logic                         rd_pending,
   output logic                         underflow_err
);
   localparam logic [STAT_WIDTH-1:0] LIMIT = STAT_WIDTH'(BUF_LIMIT);

   logic [STAT_WIDTH-1:0] fccr [NUM_VC];
   logic [STAT_WIDTH-1:0] qlen [NUM_VC];
   logic [NUM_VC-1:0] dirty, refresh, enq_hit, deq_hit, inc, dec, empty, clr_mask;

   // Indices >= NUM_VC never match any slot, so they are silently dropped.
   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         enq_hit[v] = enq_valid && enq_vc == QUEUE_INDEX_WIDTH'(v);
         deq_hit[v] = deq_valid && deq_vc == QUEUE_INDEX_WIDTH'(v);
         empty[v]   = qlen[v] == '0;
         inc[v]     = enq_hit[v] && !deq_hit[v] && qlen[v] != LIMIT;
         dec[v]     = deq_hit[v] && !enq_hit[v] && !empty[v];
      end
      clr_mask = clr ? NUM_VC'(1) << idx : '0;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int v = 0; v < NUM_VC; v++) begin
            fccr[v] <= '0;
            qlen[v] <= '0;
         end
         dirty         <= '0;
         refresh       <= '0;
         underflow_err <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            fccr[v] <= fccr[v] + STAT_WIDTH'(enq_hit[v]);
            qlen[v] <= qlen[v] + STAT_WIDTH'(inc[v]) - STAT_WIDTH'(dec[v]);
         end
         dirty         <= (dirty & ~clr_mask) | enq_hit | dec;
         refresh       <= refresh_all ? '1 : refresh & ~clr_mask;
         underflow_err <= |(deq_hit & ~enq_hit & empty);
      end

   assign rd_fccr    = fccr[idx];
   assign rd_qlen    = qlen[idx];
   assign rd_pending = dirty[idx] | refresh[idx];
endmodule

// File: rtl/fcp_update_gen.sv
// fcp_update_gen: scans per-VC credit state and emits FCP update words for
// changed or periodically refreshed VCs on an AXIS master.
module fcp_update_gen
   import fcp_pkg::*;
#(
   parameter int NUM_VC            = 16,
   parameter int QUEUE_INDEX_WIDTH = 15,
   parameter int STAT_WIDTH        = 32,
   parameter int AXIS_WIDTH        = 128,
   parameter int BUF_LIMIT         = 1024,
   parameter int REFRESH_CYCLES    = 4096
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic                         enq_valid,
   input  logic [QUEUE_INDEX_WIDTH-1:0] enq_vc,
   input  logic                         deq_valid,
   input  logic [QUEUE_INDEX_WIDTH-1:0] deq_vc,
   output logic [AXIS_WIDTH-1:0]        m_axis_fcp_tdata,
   output logic                         m_axis_fcp_tvalid,
   input  logic                         m_axis_fcp_tready,
   output logic                         underflow_err
);
   localparam int PW = $clog2(NUM_VC);
   localparam int TW = $clog2(REFRESH_CYCLES);

   fcp_state_e state, state_nxt;
   logic [PW-1:0] ptr;
   logic [TW-1:0] timer;
   logic refresh_all, pending, load;
   logic [STAT_WIDTH-1:0] rd_fccr, rd_qlen;
   fcp_upd_t upd;

   assign refresh_all = timer == TW'(REFRESH_CYCLES - 1);

   fcp_vc_state #(
      .NUM_VC(NUM_VC), .QUEUE_INDEX_WIDTH(QUEUE_INDEX_WIDTH),
      .STAT_WIDTH(STAT_WIDTH), .BUF_LIMIT(BUF_LIMIT), .PW(PW)
   ) u_state (
      .clk(clk), .rst_n(rst_n),
      .enq_valid(enq_valid), .enq_vc(enq_vc),
      .deq_valid(deq_valid), .deq_vc(deq_vc),
      .refresh_all(refresh_all), .clr(load), .idx(ptr),
      .rd_fccr(rd_fccr), .rd_qlen(rd_qlen), .rd_pending(pending),
      .underflow_err(underflow_err)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= SCAN;
      else state <= state_nxt;

   always_comb
      state_nxt = state == SCAN ? (load ? SEND : SCAN) : (m_axis_fcp_tready ? SCAN : SEND);

   // Snapshot uses the pre-update registered values; a same-cycle event re-dirties the VC.
   always_comb begin
      load     = state == SCAN && enable && pending;
      upd.vc   = FCP_VC_W'(ptr);
      upd.fccr = FCP_STAT_W'(rd_fccr);
      upd.qlen = FCP_STAT_W'(rd_qlen);
      upd.fccl = FCP_STAT_W'(rd_fccr + (STAT_WIDTH'(BUF_LIMIT) - rd_qlen));
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         timer             <= '0;
         ptr               <= '0;
         m_axis_fcp_tdata  <= '0;
         m_axis_fcp_tvalid <= 1'b0;
      end else begin
         timer <= refresh_all ? '0 : timer + 1'b1;
         if (state == SCAN && enable) ptr <= ptr + 1'b1;
         if (load) m_axis_fcp_tdata <= AXIS_WIDTH'(fcp_pack(upd));
         if (load) m_axis_fcp_tvalid <= 1'b1;
         else if (m_axis_fcp_tready) m_axis_fcp_tvalid <= 1'b0;
      end
endmodule

// File: tb/tb_fcp_update_gen.sv
// tb_fcp_update_gen: directed scenario tests for the FCP credit update generator.
module tb_fcp_update_gen;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b0;
   logic enq_valid = 1'b0;
   logic [14:0] enq_vc = '0;
   logic deq_valid = 1'b0;
   logic [14:0] deq_vc = '0;
   logic [127:0] tdata;
   logic tvalid;
   logic tready = 1'b0;
   logic underflow_err;

   int tests_run = 0;
   int tests_failed = 0;
   int uf_cnt = 0;
   logic [127:0] words[$];

   fcp_update_gen dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .enq_valid(enq_valid), .enq_vc(enq_vc),
      .deq_valid(deq_valid), .deq_vc(deq_vc),
      .m_axis_fcp_tdata(tdata), .m_axis_fcp_tvalid(tvalid),
      .m_axis_fcp_tready(tready), .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   // Transfers are logged half a cycle before the edge that completes them.
   always @(negedge clk)
      if (rst_n) begin
         if (tvalid && tready) words.push_back(tdata);
         if (underflow_err) uf_cnt++;
      end

   function automatic logic [127:0] exp_word(int vc, int fccr, int qlen, int fccl);
      return {17'd0, 15'(vc), 32'(fccr), 32'(qlen), 32'(fccl)};
   endfunction

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic en);
      rst_n = 1'b0;
      enable = 1'b0; enq_valid = 1'b0; deq_valid = 1'b0; tready = 1'b0;
      tick(3);
      words.delete();
      uf_cnt = 0;
      enable = en;
      rst_n = 1'b1;
   endtask

   task automatic enq(int vc);
      enq_valid = 1'b1; enq_vc = 15'(vc);
      tick();
      enq_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick(2);
      tests_run++;
      if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
      tests_run++;
      if (tdata !== '0) begin tests_failed++; $display("FAIL reset_tdata got %h want 0", tdata); end
      tests_run++;
      if (underflow_err !== 1'b0) begin tests_failed++; $display("FAIL reset_uf got %b want 0", underflow_err); end
   endtask

   task automatic test_single;
      logic [127:0] e;
      do_reset(1'b0);
      tready = 1'b1;
      repeat (3) enq(2);
      enable = 1'b1;
      tick(60);
      e = exp_word(2, 3, 3, 1024);
      tests_run++;
      if (words.size() != 1) begin tests_failed++; $display("FAIL single_count got %0d want 1", words.size()); end
      tests_run++;
      if (words.size() < 1 || words[0] !== e) begin tests_failed++; $display("FAIL single_word got %h want %h", words.size() ? words[0] : '0, e); end
      tick(200);
      tests_run++;
      if (words.size() != 1) begin tests_failed++; $display("FAIL single_quiet got %0d want 1", words.size()); end
   endtask

   task automatic test_enq_deq;
      logic [127:0] e;
      do_reset(1'b0);
      tready = 1'b1;
      enq(5);
      enq(5);
      deq_valid = 1'b1; deq_vc = 15'd5;
      tick();
      enq_valid = 1'b1; enq_vc = 15'd5;
      tick();
      enq_valid = 1'b0; deq_valid = 1'b0;
      enable = 1'b1;
      tick(60);
      e = exp_word(5, 3, 1, 1026);
      tests_run++;
      if (words.size() != 1 || words[0] !== e) begin tests_failed++; $display("FAIL vc5_word got n=%0d %h want %h", words.size(), words.size() ? words[0] : '0, e); end
      tests_run++;
      if (uf_cnt != 0) begin tests_failed++; $display("FAIL vc5_uf got %0d want 0", uf_cnt); end
   endtask

   task automatic test_backpressure;
      logic [127:0] e;
      int bad;
      do_reset(1'b0);
      enq(1);
      enable = 1'b1;
      for (int i = 0; i < 40 && !tvalid; i++) tick();
      e = exp_word(1, 1, 1, 1024);
      tests_run++;
      if (tvalid !== 1'b1) begin tests_failed++; $display("FAIL bp_tvalid_rise got %b want 1", tvalid); end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tvalid !== 1'b1 || tdata !== e) bad++;
      end
      tests_run++;
      if (bad != 0) begin tests_failed++; $display("FAIL bp_hold got %0d unstable cycles want 0 (tdata %h want %h)", bad, tdata, e); end
      tready = 1'b1;
      tick(20);
      tests_run++;
      if (words.size() != 1 || words[0] !== e) begin tests_failed++; $display("FAIL bp_transfer got n=%0d %h want 1 %h", words.size(), words.size() ? words[0] : '0, e); end
   endtask

   task automatic test_underflow;
      logic [127:0] e;
      do_reset(1'b1);
      tready = 1'b1;
      deq_valid = 1'b1; deq_vc = 15'd7;
      tick();
      deq_valid = 1'b0;
      tick(40);
      tests_run++;
      if (uf_cnt != 1) begin tests_failed++; $display("FAIL uf_pulse got %0d cycles want 1", uf_cnt); end
      tests_run++;
      if (words.size() != 0) begin tests_failed++; $display("FAIL uf_noword got %0d want 0", words.size()); end
      deq_valid = 1'b1; deq_vc = 15'd20;
      enq_valid = 1'b1; enq_vc = 15'd100;
      tick();
      deq_valid = 1'b0; enq_valid = 1'b0;
      tick(40);
      tests_run++;
      if (uf_cnt != 1 || words.size() != 0) begin tests_failed++; $display("FAIL oob_ignored got uf=%0d n=%0d want 1 0", uf_cnt, words.size()); end
      enable = 1'b0;
      enq(7);
      enable = 1'b1;
      tick(40);
      e = exp_word(7, 1, 1, 1024);
      tests_run++;
      if (words.size() != 1 || words[0] !== e) begin tests_failed++; $display("FAIL uf_qlen got n=%0d %h want %h", words.size(), words.size() ? words[0] : '0, e); end
   endtask

   task automatic test_back_to_back;
      int vcs[3] = '{0, 1, 3};
      do_reset(1'b0);
      tready = 1'b1;
      foreach (vcs[i]) enq(vcs[i]);
      enable = 1'b1;
      tick(40);
      tests_run++;
      if (words.size() != 3) begin tests_failed++; $display("FAIL b2b_count got %0d want 3", words.size()); end
      foreach (vcs[i]) begin
         tests_run++;
         if (i >= words.size() || words[i] !== exp_word(vcs[i], 1, 1, 1024)) begin
            tests_failed++;
            $display("FAIL b2b_word%0d got %h want %h", i, i < words.size() ? words[i] : '0, exp_word(vcs[i], 1, 1, 1024));
         end
      end
   endtask

   task automatic test_refresh;
      do_reset(1'b1);
      tready = 1'b1;
      tick(4096 + 60);
      tests_run++;
      if (words.size() != 16) begin tests_failed++; $display("FAIL refresh_count got %0d want 16", words.size()); end
      for (int v = 0; v < 16; v++) begin
         tests_run++;
         if (v >= words.size() || words[v] !== exp_word(v, 0, 0, 1024)) begin
            tests_failed++;
            $display("FAIL refresh_word%0d got %h want %h", v, v < words.size() ? words[v] : '0, exp_word(v, 0, 0, 1024));
         end
      end
   endtask

   task automatic test_reset_mid;
      do_reset(1'b0);
      enq(3);
      enable = 1'b1;
      for (int i = 0; i < 40 && !tvalid; i++) tick();
      tests_run++;
      if (tvalid !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_pre got %b want 1", tvalid); end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (tvalid !== 1'b0 || tdata !== '0) begin tests_failed++; $display("FAIL rst_mid_drop got %b %h want 0 0", tvalid, tdata); end
      tick(2);
      words.delete();
      rst_n = 1'b1;
      tready = 1'b1;
      tick(100);
      tests_run++;
      if (words.size() != 0) begin tests_failed++; $display("FAIL rst_mid_quiet got %0d want 0", words.size()); end
      enable = 1'b0;
      enq(3);
      enable = 1'b1;
      tick(40);
      tests_run++;
      if (words.size() != 1 || words[0] !== exp_word(3, 1, 1, 1024)) begin
         tests_failed++;
         $display("FAIL rst_mid_after got n=%0d %h want %h", words.size(), words.size() ? words[0] : '0, exp_word(3, 1, 1, 1024));
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_enq_deq;
      test_backpressure;
      test_underflow;
      test_back_to_back;
      test_refresh;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
